mux_n_pipe: RTL

- Parametrised N-input data selector with a registered output stage and a valid/ready handshake; successor to the combinational 4-input select mux.
- Adds a two-entry skid buffer so the output can stall without a combinational ready path from consumer to producer.
- Adds a flush input and a sticky out-of-range-select error flag.
- Used in core pipeline datapaths (forwarding, writeback-source select) wherever a selected operand must cross a stage boundary under backpressure.

---
 rtl/mux_n_pipe.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/mux_n_pipe.sv
// mux_n_pipe: N-input data selector with a registered output stage, a two-entry
// skid buffer on a valid/ready handshake, pipeline flush and a sticky bad-select flag.
`ifndef DATA_WIDTH
`define DATA_WIDTH 32
`endif

module mux_n_pipe #(
    parameter int WIDTH  = `DATA_WIDTH,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    flush,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [SEL_W-1:0]        in_sel,
    input  logic                    in_valid,
    output logic                    in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sel_err
);

    // Occupancy is encoded directly by {skid_valid, out_valid}; 2'b10 is never entered.
    typedef enum logic [1:0] {
        ST_EMPTY = 2'b00,
        ST_ONE   = 2'b01,
        ST_BAD   = 2'b10,
        ST_FULL  = 2'b11
    } state_e;

    // True when sel addresses one of the NUM_IN populated inputs.
    function automatic logic sel_in_range(input logic [SEL_W-1:0] sel);
        logic legal;
        legal = 1'b0;
        for (int k = 0; k < NUM_IN; k++) begin
            legal = legal | (sel == SEL_W'(k));
        end
        return legal;
    endfunction

    // Selected word; any select that matches no populated input falls back to input 0.
    function automatic logic [WIDTH-1:0] pick_word(
        input logic [NUM_IN*WIDTH-1:0] data,
        input logic [SEL_W-1:0]        sel
    );
        logic [WIDTH-1:0] word;
        word = data[WIDTH-1:0];
        for (int k = 1; k < NUM_IN; k++) begin
            word = (sel == SEL_W'(k)) ? data[k*WIDTH +: WIDTH] : word;
        end
        return word;
    endfunction

    logic [WIDTH-1:0] out_data_r;
    logic             out_valid_r;
    logic [WIDTH-1:0] skid_data_r;
    logic             skid_valid_r;
    logic             in_ready_r;
    logic             sel_err_r;

    logic [WIDTH-1:0] nxt_out_data_s;
    logic             nxt_out_valid_s;
    logic [WIDTH-1:0] nxt_skid_data_s;
    logic             nxt_skid_valid_s;
    logic             nxt_in_ready_s;
    logic             nxt_sel_err_s;

    logic [WIDTH-1:0] sel_word_s;
    logic             sel_legal_s;
    logic             in_xfer_s;
    logic             out_xfer_s;
    state_e           state_s;

    assign sel_word_s  = pick_word(in_data, in_sel);
    assign sel_legal_s = sel_in_range(in_sel);
    assign in_xfer_s   = in_valid && in_ready_r;
    assign out_xfer_s  = out_valid_r && out_ready;
    assign state_s     = state_e'({skid_valid_r, out_valid_r});

    // Next-state and datapath steering for the main/skid register pair.
    always_comb begin
        nxt_out_data_s   = out_data_r;
        nxt_out_valid_s  = out_valid_r;
        nxt_skid_data_s  = skid_data_r;
        nxt_skid_valid_s = skid_valid_r;
        nxt_sel_err_s    = sel_err_r;

        case (state_s)
            ST_EMPTY: begin
                if (in_xfer_s) begin
                    nxt_out_valid_s = 1'b1;
                    nxt_out_data_s  = sel_word_s;
                end else begin
                    nxt_out_valid_s = 1'b0;
                end
            end
            ST_ONE: begin
                if (in_xfer_s && out_xfer_s) begin
                    nxt_out_data_s = sel_word_s;
                end else if (in_xfer_s) begin
                    nxt_skid_valid_s = 1'b1;
                    nxt_skid_data_s  = sel_word_s;
                end else if (out_xfer_s) begin
                    nxt_out_valid_s = 1'b0;
                end else begin
                    nxt_out_valid_s = 1'b1;
                end
            end
            ST_FULL: begin
                if (out_xfer_s) begin
                    nxt_out_data_s   = skid_data_r;
                    nxt_skid_valid_s = 1'b0;
                end else begin
                    nxt_skid_valid_s = 1'b1;
                end
            end
            default: begin
                // Recover an orphaned skid word into the main register rather than lose it.
                nxt_out_data_s   = skid_data_r;
                nxt_out_valid_s  = 1'b1;
                nxt_skid_valid_s = 1'b0;
            end
        endcase

        if (flush) begin
            // Data registers hold; only the valid bits and the error flag are cleared.
            nxt_out_data_s   = out_data_r;
            nxt_out_valid_s  = 1'b0;
            nxt_skid_data_s  = skid_data_r;
            nxt_skid_valid_s = 1'b0;
            nxt_sel_err_s    = 1'b0;
        end else if (in_xfer_s && !sel_legal_s) begin
            nxt_sel_err_s = 1'b1;
        end else begin
            nxt_sel_err_s = sel_err_r;
        end

        nxt_in_ready_s = !nxt_skid_valid_s;
    end

    // State registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            out_data_r   <= '0;
            out_valid_r  <= 1'b0;
            skid_data_r  <= '0;
            skid_valid_r <= 1'b0;
            in_ready_r   <= 1'b1;
            sel_err_r    <= 1'b0;
        end else begin
            out_data_r   <= nxt_out_data_s;
            out_valid_r  <= nxt_out_valid_s;
            skid_data_r  <= nxt_skid_data_s;
            skid_valid_r <= nxt_skid_valid_s;
            in_ready_r   <= nxt_in_ready_s;
            sel_err_r    <= nxt_sel_err_s;
        end
    end

    assign in_ready  = in_ready_r;
    assign out_data  = out_data_r;
    assign out_valid = out_valid_r;
    assign sel_err   = sel_err_r;

endmodule
